shift_rows_stream: RTL and testbench

//   Byte-serial AES ShiftRows unit for the datapath's streaming byte interface.
//   - Accepts a 128-bit AES state one byte per cycle in FIPS-197 column-major order:

---
 rtl/shift_rows_stream.sv | 88 ++++++++
 tb/tb_shift_rows_stream.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_stream.sv
// Byte-serial AES ShiftRows/InvShiftRows over a two-bank ping-pong buffer.
// One state fills while the other drains; output order is strictly FIFO by state.
module shift_rows_stream #(
  parameter bit INVERSE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [0:7] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [0:7] out_byte,
  output logic       out_last
);

  logic [0:7] bank_q [2][16];
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic [1:0] full_q, full_d;
  logic [3:0] src_idx;
  logic       wr_en;
  logic       rd_en;

  always_comb begin
    in_ready  = !full_q[wr_bank_q];
    out_valid = full_q[rd_bank_q];
    wr_en     = in_valid && in_ready;
    rd_en     = out_valid && out_ready;

    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;

    // Set and clear always hit different banks, so both may apply in one cycle.
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
      if (wr_cnt_q == 4'hF) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (rd_en) begin
      rd_cnt_d = rd_cnt_q + 4'd1;
      if (rd_cnt_q == 4'hF) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end

    // Row r = k%4 reads from column offset +r (forward) or -r (inverse), mod 16.
    if (INVERSE) begin
      src_idx = rd_cnt_q - {rd_cnt_q[1:0], 2'b00};
    end else begin
      src_idx = rd_cnt_q + {rd_cnt_q[1:0], 2'b00};
    end

    out_byte = out_valid ? bank_q[rd_bank_q][src_idx] : 8'h00;
    out_last = out_valid && (rd_cnt_q == 4'hF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= 4'd0;
      rd_cnt_q  <= 4'd0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      bank_q[wr_bank_q][wr_cnt_q] <= in_byte;
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream: table vectors for both directions plus
// backpressure, streaming, mid-operation reset and forward->inverse round trip.
module tb_shift_rows_stream;

  logic       clk;
  logic       rst_n;
  logic       chain;

  logic       f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_out_last;
  logic [7:0] f_in_byte, f_out_byte;
  logic       i_in_valid, i_in_ready, i_out_valid, i_out_ready, i_out_last;
  logic [7:0] i_in_byte, i_out_byte;
  logic       tb_f_ordy, tb_i_ivld;
  logic [7:0] tb_i_ibyte;

  assign f_out_ready = chain ? i_in_ready  : tb_f_ordy;
  assign i_in_valid  = chain ? f_out_valid : tb_i_ivld;
  assign i_in_byte   = chain ? f_out_byte  : tb_i_ibyte;

  shift_rows_stream #(.INVERSE(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_byte(f_in_byte),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_byte(f_out_byte),
    .out_last(f_out_last)
  );

  shift_rows_stream #(.INVERSE(1'b1)) dut_i (
    .clk(clk), .rst_n(rst_n),
    .in_valid(i_in_valid), .in_ready(i_in_ready), .in_byte(i_in_byte),
    .out_valid(i_out_valid), .out_ready(i_out_ready), .out_byte(i_out_byte),
    .out_last(i_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           inv;
    logic [127:0] in_s;
    logic [127:0] exp_s;
  } vec_t;

  vec_t vecs[4];

  int n_cmp;
  int n_fail;

  // Scoreboard state, index 0 = forward instance, 1 = inverse instance.
  logic [127:0] acc[2];
  int           acc_n[2];
  logic [7:0]   exp_buf[2][256];
  int           wp[2];
  int           rp[2];
  int           out_n[2];
  bit           stall[2];
  logic [7:0]   prev_b[2];
  logic         prev_l[2];
  logic [7:0]   rt_buf[256];
  int           rt_wp;
  int           rt_rp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Byte k of the shifted state: row r = k%4, column c = k/4.
  function automatic logic [7:0] model_byte(input logic [127:0] s, input int k, input bit inv);
    int r;
    int c;
    int sc;
    r  = k % 4;
    c  = k / 4;
    sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
    return s[8*(r + 4*sc) +: 8];
  endfunction

  task automatic mon(input int id, input bit inv,
                     input logic ovld, input logic ordy, input logic [7:0] ob, input logic ol,
                     input logic ivld, input logic irdy, input logic [7:0] ib);
    if (!rst_n) begin
      acc_n[id] = 0;
      rp[id]    = wp[id];
      out_n[id] = 0;
      stall[id] = 0;
      if (id == 0) rt_rp = rt_wp;
      return;
    end
    if (stall[id]) check("hold_under_stall", {ovld, ol, ob}, {1'b1, prev_l[id], prev_b[id]});
    if (ovld && ordy) begin
      if (rp[id] == wp[id]) begin
        check("spurious_out", 32'(ob), 32'h100);
      end else begin
        check("stream_byte", 32'(ob), 32'(exp_buf[id][rp[id] % 256]));
        check("stream_last", 32'(ol), 32'(out_n[id] % 16 == 15));
        rp[id]++;
        out_n[id]++;
      end
      if (id == 1 && chain) begin
        if (rt_rp == rt_wp) begin
          check("round_trip_extra", 32'(ob), 32'h100);
        end else begin
          check("round_trip", 32'(ob), 32'(rt_buf[rt_rp % 256]));
          rt_rp++;
        end
      end
    end
    stall[id]  = ovld && !ordy;
    prev_b[id] = ob;
    prev_l[id] = ol;
    if (ivld && irdy) begin
      acc[id][8*acc_n[id] +: 8] = ib;
      acc_n[id]++;
      if (id == 0 && chain) begin
        rt_buf[rt_wp % 256] = ib;
        rt_wp++;
      end
      if (acc_n[id] == 16) begin
        for (int k = 0; k < 16; k++) begin
          exp_buf[id][wp[id] % 256] = model_byte(acc[id], k, inv);
          wp[id]++;
        end
        acc_n[id] = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon(0, 1'b0, f_out_valid, f_out_ready, f_out_byte, f_out_last, f_in_valid, f_in_ready, f_in_byte);
    mon(1, 1'b1, i_out_valid, i_out_ready, i_out_byte, i_out_last, i_in_valid, i_in_ready, i_in_byte);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int id, input logic v, input logic [7:0] b);
    if (id == 0) begin
      f_in_valid = v;
      f_in_byte  = b;
    end else begin
      tb_i_ivld  = v;
      tb_i_ibyte = b;
    end
  endtask

  function automatic logic get_ovld(input int id);
    return (id == 0) ? f_out_valid : i_out_valid;
  endfunction

  task automatic run_vec(input int v);
    int         id;
    int         n;
    logic [7:0] got[16];
    logic       gl[16];
    id = vecs[v].inv ? 1 : 0;
    tb_f_ordy   = 1'b1;
    i_out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      set_in(id, 1'b1, vecs[v].in_s[8*k +: 8]);
      if (k == 15) check("vld_before_last_in", 32'(get_ovld(id)), 32'd0);
      tick();
    end
    set_in(id, 1'b0, 8'h00);
    check("vld_after_last_in", 32'(get_ovld(id)), 32'd1);
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 16; cyc++) begin
      if (get_ovld(id)) begin
        got[n] = (id == 0) ? f_out_byte : i_out_byte;
        gl[n]  = (id == 0) ? f_out_last : i_out_last;
        n++;
      end
      tick();
    end
    check("vec_collect_count", 32'(n), 32'd16);
    for (int k = 0; k < n; k++) begin
      check("vec_byte", 32'(got[k]), 32'(vecs[v].exp_s[8*k +: 8]));
      check("vec_last", 32'(gl[k]), 32'(k == 15));
    end
  endtask

  task automatic check_reset_state(input int id);
    if (id == 0) begin
      check("rst_in_ready_f", 32'(f_in_ready), 32'd1);
      check("rst_out_f", {f_out_valid, f_out_last, f_out_byte}, 32'd0);
    end else begin
      check("rst_in_ready_i", 32'(i_in_ready), 32'd1);
      check("rst_out_i", {i_out_valid, i_out_last, i_out_byte}, 32'd0);
    end
  endtask

  initial begin
    int acc_cnt;
    int drained;
    int fed;
    int cyc;

    n_cmp = 0;
    n_fail = 0;
    rt_wp = 0;
    rt_rp = 0;
    for (int i = 0; i < 2; i++) begin
      acc[i] = '0; acc_n[i] = 0; wp[i] = 0; rp[i] = 0; out_n[i] = 0;
      stall[i] = 0; prev_b[i] = 8'h00; prev_l[i] = 1'b0;
    end

    vecs[0].inv = 1'b0;
    vecs[0].in_s  = 128'h0F0E0D0C0B0A09080706050403020100;
    vecs[0].exp_s = 128'h0B06010C07020D08030E09040F0A0500;
    vecs[1].inv = 1'b1;
    vecs[1].in_s  = 128'h0F0E0D0C0B0A09080706050403020100;
    vecs[1].exp_s = 128'h0306090C0F0205080B0E0104070A0D00;
    vecs[2].inv = 1'b0;
    vecs[2].in_s  = 128'h1F1E1D1C1B1A19181716151413121110;
    vecs[2].exp_s = 128'h1B16111C17121D18131E19141F1A1510;
    vecs[3].inv = 1'b1;
    vecs[3].in_s  = 128'h1F1E1D1C1B1A19181716151413121110;
    vecs[3].exp_s = 128'h1316191C1F1215181B1E1114171A1D10;

    chain = 1'b0;
    rst_n = 1'b0;
    f_in_valid = 1'b0; f_in_byte = 8'h00; tb_f_ordy = 1'b0;
    tb_i_ivld = 1'b0; tb_i_ibyte = 8'h00; i_out_ready = 1'b0;
    #1;
    tick();
    tick();
    check_reset_state(0);
    check_reset_state(1);
    rst_n = 1'b1;
    tick();

    // Table vectors: forward and inverse, two input patterns each.
    for (int v = 0; v < 4; v++) run_vec(v);

    // Backpressure: both banks fill, then the older state drains.
    tb_f_ordy = 1'b0;
    acc_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      f_in_valid = 1'b1;
      f_in_byte  = 8'h40 + 8'(acc_cnt);
      if (f_in_ready) acc_cnt++;
      tick();
    end
    check("bp_accepted", 32'(acc_cnt), 32'd32);
    check("bp_in_ready_low", 32'(f_in_ready), 32'd0);
    f_in_valid = 1'b0;
    tb_f_ordy  = 1'b1;
    drained = 0;
    for (int c = 0; c < 20 && drained < 16; c++) begin
      if (f_out_valid) drained++;
      if (drained == 16) check("bp_in_ready_at_16th", 32'(f_in_ready), 32'd0);
      tick();
    end
    check("bp_drained", 32'(drained), 32'd16);
    check("bp_in_ready_back", 32'(f_in_ready), 32'd1);
    for (int c = 0; c < 40 && f_out_valid; c++) tick();
    check("bp_all_drained", 32'(wp[0] - rp[0]), 32'd0);

    // Streaming: four states with random gaps on both sides.
    fed = 0;
    cyc = 0;
    while ((fed < 64 || rp[0] != wp[0] || f_out_valid) && cyc < 2000) begin
      f_in_valid = (fed < 64) && ($urandom_range(3) != 0);
      f_in_byte  = 8'($urandom);
      tb_f_ordy  = ($urandom_range(2) != 0);
      if (f_in_valid && f_in_ready) fed++;
      tick();
      cyc++;
    end
    f_in_valid = 1'b0;
    check("stream_done_in_budget", 32'(cyc < 2000), 32'd1);
    check("stream_no_loss", 32'(wp[0] - rp[0]), 32'd0);
    check("stream_outputs", 32'(out_n[0] % 64), 32'd0);

    // Reset with one bank full and 7 bytes of the next state written.
    tb_f_ordy = 1'b0;
    for (int k = 0; k < 23; k++) begin
      f_in_valid = 1'b1;
      f_in_byte  = 8'h60 + 8'(k);
      tick();
    end
    f_in_valid = 1'b0;
    check("pre_reset_full", 32'(f_out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state(0);
    tb_f_ordy = 1'b1;
    tick();
    check("post_reset_no_out", 32'(f_out_valid), 32'd0);
    run_vec(0);

    // Round trip: forward chained into inverse.
    chain = 1'b1;
    fed = 0;
    cyc = 0;
    while ((fed < 48 || rp[0] != wp[0] || rp[1] != wp[1] || acc_n[1] != 0 ||
            f_out_valid || i_out_valid) && cyc < 2000) begin
      f_in_valid  = (fed < 48) && ($urandom_range(3) != 0);
      f_in_byte   = 8'($urandom);
      i_out_ready = ($urandom_range(2) != 0);
      if (f_in_valid && f_in_ready) fed++;
      tick();
      cyc++;
    end
    f_in_valid = 1'b0;
    check("rt_done_in_budget", 32'(cyc < 2000), 32'd1);
    check("rt_all_returned", 32'(rt_wp - rt_rp), 32'd0);
    check("rt_byte_count", 32'(rt_wp), 32'd48);
    chain = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
